// File: rtl/wb_pkg.sv
// Wishbone request/response bundles shared by the masters, the arbiter and the crossbar.
package wb_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_h2d_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] dat;
  } wb_d2h_t;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: one granted master at a time onto the crossbar port,
// with a watchdog that terminates transfers the slave never acknowledges.
module wb_arbiter_rr
  import wb_pkg::*;
#(
  parameter int          NUM_MASTERS    = 2,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  wb_h2d_t                wb_m_i [NUM_MASTERS],
  output wb_d2h_t                wb_m_o [NUM_MASTERS],
  output wb_h2d_t                wb_s_o,
  input  wb_d2h_t                wb_s_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   tmo_q, tmo_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [IW-1:0]          pick;
  logic [IW-1:0]          cand;

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      req[k] = wb_m_i[k].cyc & wb_m_i[k].stb;
    end
  end

  // Search starts just past the last served master so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = IW'((int'(last_q) + i) % NUM_MASTERS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    timer_d = timer_q;
    tmo_d   = 1'b0;
    wb_s_o  = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      wb_m_o[k] = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d       = BUSY;
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          timer_d       = '0;
        end
      end
      BUSY: begin
        wb_s_o         = wb_m_i[gidx_q];
        wb_m_o[gidx_q] = wb_s_i;
        if (wb_s_i.ack || !wb_m_i[gidx_q].cyc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end else if (timer_q == TMO_LAST) begin
          // Watchdog: fake the ack towards the master and pull the request off the bus.
          wb_s_o             = '0;
          wb_m_o[gidx_q].ack = 1'b1;
          wb_m_o[gidx_q].dat = TIMEOUT_DATA;
          tmo_d              = 1'b1;
          state_d            = IDLE;
          grant_d            = '0;
          last_d             = gidx_q;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (3 masters, 8-cycle watchdog): a cycle table plus reset sequences.
module tb_wb_arbiter_rr;
  import wb_pkg::*;

  localparam int NM = 3;

  logic          clk = 1'b0;
  logic          rst;
  wb_h2d_t       m_i [NM];
  wb_d2h_t       m_o [NM];
  wb_h2d_t       s_o;
  wb_d2h_t       s_i;
  logic [NM-1:0] grant;
  logic          tmo;

  always #5 clk = ~clk;

  wb_arbiter_rr #(
    .NUM_MASTERS   (NM),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wb_m_i   (m_i),
    .wb_m_o   (m_o),
    .wb_s_o   (s_o),
    .wb_s_i   (s_i),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        sack;
    logic [31:0] sdat;
    logic [2:0]  egnt;
    logic [2:0]  emack;
    logic        escyc;
    logic [31:0] esadr;
    logic [31:0] edat;
    logic        etmo;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic r, logic [2:0] req, logic sack, logic [31:0] sdat,
                              logic [2:0] egnt, logic [2:0] emack, logic escyc,
                              logic [31:0] esadr, logic [31:0] edat, logic etmo);
    vec_t v;
    v.rst = r; v.req = req; v.sack = sack; v.sdat = sdat;
    v.egnt = egnt; v.emack = emack; v.escyc = escyc;
    v.esadr = esadr; v.edat = edat; v.etmo = etmo;
    return v;
  endfunction

  task automatic drive(input logic r, input logic [2:0] req, input logic sack,
                       input logic [31:0] sdat);
    rst = r;
    for (int k = 0; k < NM; k++) begin
      m_i[k]     = '0;
      m_i[k].cyc = req[k];
      m_i[k].stb = req[k];
      m_i[k].sel = 4'hF;
      m_i[k].adr = 32'h100 * (k + 1);
      m_i[k].dat = 32'hA0 + k;
    end
    s_i.ack = sack;
    s_i.dat = sdat;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    logic [2:0]  mack;
    logic [31:0] dat_or;
    mack   = '0;
    dat_or = '0;
    for (int k = 0; k < NM; k++) begin
      mack[k] = m_o[k].ack;
      dat_or  = dat_or | m_o[k].dat;
    end
    chk({tag, ".grant"}, 32'(grant), 32'(v.egnt));
    chk({tag, ".mack"},  32'(mack),  32'(v.emack));
    chk({tag, ".scyc"},  32'(s_o.cyc), 32'(v.escyc));
    chk({tag, ".sadr"},  s_o.adr, v.esadr);
    chk({tag, ".mdat"},  dat_or, v.edat);
    chk({tag, ".tmo"},   32'(tmo), 32'(v.etmo));
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.rst, v.req, v.sack, v.sdat);
    #1;
    check_outputs(tag, v);
  endtask

  initial begin
    // Single M0 transfer, slave acks on the 4th BUSY cycle.
    vecs.push_back(mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    repeat (3) vecs.push_back(mk(0, 3'b001, 0, 0, 3'b001, 3'b000, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 32'h1111_0001, 3'b001, 3'b001, 1, 32'h100, 32'h1111_0001, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    // M0+M1 continuous, 1-cycle slave: alternation starting after last=0.
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b010, 3'b010, 1, 32'h200, 32'h22, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b001, 3'b001, 1, 32'h100, 32'h22, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h22, 3'b010, 3'b010, 1, 32'h200, 32'h22, 0));
    // M0 alone to set last=0, then M2 alone, then M0+M1.
    vecs.push_back(mk(0, 3'b001, 1, 32'h22, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 32'h22, 3'b001, 3'b001, 1, 32'h100, 32'h22, 0));
    vecs.push_back(mk(0, 3'b100, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b100, 1, 32'h33, 3'b100, 3'b100, 1, 32'h300, 32'h33, 0));
    vecs.push_back(mk(0, 3'b011, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h44, 3'b001, 3'b001, 1, 32'h100, 32'h44, 0));
    vecs.push_back(mk(0, 3'b011, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 1, 32'h44, 3'b010, 3'b010, 1, 32'h200, 32'h44, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    // Watchdog: no slave ack, forced termination on the 8th BUSY cycle.
    vecs.push_back(mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    repeat (7) vecs.push_back(mk(0, 3'b001, 0, 0, 3'b001, 3'b000, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 3'b001, 0, 0, 3'b001, 3'b001, 0, 0, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    // Slave ack lands on the watchdog cycle: slave wins, no pulse.
    vecs.push_back(mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    repeat (7) vecs.push_back(mk(0, 3'b001, 0, 0, 3'b001, 3'b000, 1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 3'b001, 1, 32'h55, 3'b001, 3'b001, 1, 32'h100, 32'h55, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    // Master abort: M1 drops cyc mid-transfer, released without ack or pulse.
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 0, 0, 3'b010, 3'b000, 1, 32'h200, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b010, 3'b000, 0, 32'h200, 0, 0));
    vecs.push_back(mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));

    // Power-on reset, then reset state.
    drive(1, 3'b000, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(0, 3'b000, 0, 0);
    #1;
    check_outputs("reset", mk(0, 3'b000, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Reset during a M1 transfer: dropped, and M0 wins first afterwards.
    step("rs0", mk(0, 3'b001, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    step("rs1", mk(0, 3'b001, 1, 32'h66, 3'b001, 3'b001, 1, 32'h100, 32'h66, 0));
    step("rs2", mk(0, 3'b010, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    step("rs3", mk(1, 3'b010, 0, 0, 3'b010, 3'b000, 1, 32'h200, 0, 0));
    step("rs4", mk(0, 3'b011, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0));
    step("rs5", mk(0, 3'b011, 0, 0, 3'b001, 3'b000, 1, 32'h100, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
